// File: rtl/fpu_subnorm_normalizer_pkg.sv
// Shared types for the subnormal normalizer: core configuration record and FSM states.
package fpu_subnorm_normalizer_pkg;

  typedef struct packed {
    int unsigned NE;
    int unsigned NF;
  } cvw_t;

  localparam cvw_t DOUBLE_CFG = '{NE: 32'd11, NF: 32'd52};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } norm_state_e;

endpackage

// File: rtl/fpu_subnorm_normalizer_if.sv
// Operand-in / result-out handshake bundle between the unpacker, the normalizer and its consumer.
interface fpu_subnorm_normalizer_if
  import fpu_subnorm_normalizer_pkg::*;
#(
  parameter cvw_t P = DOUBLE_CFG
) ();

  localparam int unsigned EW = P.NE + 2;
  localparam int unsigned LW = $clog2(P.NF + 1);

  logic          InValid;
  logic          InReady;
  logic          SgnIn;
  logic [P.NE-1:0] ExpIn;
  logic [P.NF:0] ManIn;
  logic          SubnormIn;
  logic          ZeroIn;
  logic          InfIn;
  logic          NaNIn;
  logic          SNaNIn;

  logic          OutValid;
  logic          OutReady;
  logic          SgnOut;
  logic [EW-1:0] ExpOut;
  logic [P.NF:0] ManOut;
  logic          ZeroOut;
  logic          InfOut;
  logic          NaNOut;
  logic          SNaNOut;
  logic [LW-1:0] LzCnt;

  modport master (
    output InValid, SgnIn, ExpIn, ManIn, SubnormIn, ZeroIn, InfIn, NaNIn, SNaNIn, OutReady,
    input  InReady, OutValid, SgnOut, ExpOut, ManOut, ZeroOut, InfOut, NaNOut, SNaNOut, LzCnt
  );

  modport slave (
    input  InValid, SgnIn, ExpIn, ManIn, SubnormIn, ZeroIn, InfIn, NaNIn, SNaNIn, OutReady,
    output InReady, OutValid, SgnOut, ExpOut, ManOut, ZeroOut, InfOut, NaNOut, SNaNOut, LzCnt
  );

endinterface

// File: rtl/fpu_subnorm_normalizer_lzc.sv
// Combinational leading-zero counter over a W-bit chunk; count is only meaningful when zero_c is 0.
module fpu_chunk_lzc #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  din,
  output logic          zero_c,
  output logic [CW-1:0] cnt_c
);

  // Scan upward so the most significant set bit wins.
  always_comb begin
    zero_c = ~|din;
    cnt_c  = '0;
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt_c = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_subnorm_normalizer.sv
// Normalizes unpacked subnormal operands to an explicit leading 1, SHIFTW bits per cycle;
// all other operand classes pass through with one cycle of latency.
module fpu_subnorm_normalizer
  import fpu_subnorm_normalizer_pkg::*;
#(
  parameter cvw_t        P      = DOUBLE_CFG,
  parameter int unsigned SHIFTW = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    Flush,
  fpu_subnorm_normalizer_if.slave bus
);

  localparam int unsigned NF = P.NF;
  localparam int unsigned EW = P.NE + 2;
  localparam int unsigned LW = $clog2(P.NF + 1);
  localparam int unsigned CW = (SHIFTW > 1) ? $clog2(SHIFTW) : 1;

  norm_state_e   state_q, state_d;
  logic          valid_q, valid_d;
  logic          sgn_q, sgn_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [NF:0]   man_q, man_d;
  logic          zero_q, zero_d;
  logic          inf_q, inf_d;
  logic          nan_q, nan_d;
  logic          snan_q, snan_d;
  logic [LW-1:0] lz_q, lz_d;

  logic [SHIFTW-1:0] top_c;
  logic              top_zero_c;
  logic [CW-1:0]     top_lz_c;
  logic              in_ready_c;
  logic              accept_c;

  assign top_c = man_q[NF -: SHIFTW];

  fpu_chunk_lzc #(.W(SHIFTW), .CW(CW)) u_lzc (
    .din    (top_c),
    .zero_c (top_zero_c),
    .cnt_c  (top_lz_c)
  );

  // Ready is held low during reset and flush so nothing is accepted then.
  assign in_ready_c = reset_n & ~Flush &
                      ((state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.OutReady));
  assign accept_c   = bus.InValid & in_ready_c;

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    exp_d   = exp_q;
    man_d   = man_q;
    zero_d  = zero_q;
    inf_d   = inf_q;
    nan_d   = nan_q;
    snan_d  = snan_q;
    lz_d    = lz_q;

    unique case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        if (top_zero_c) begin
          man_d = man_q << SHIFTW;
          exp_d = exp_q - EW'(SHIFTW);
          lz_d  = lz_q + LW'(SHIFTW);
        end else begin
          man_d   = man_q << top_lz_c;
          exp_d   = exp_q - EW'(top_lz_c);
          lz_d    = lz_q + LW'(top_lz_c);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.OutReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new operand overrides whatever the current state would do (IDLE or draining DONE).
    if (accept_c) begin
      sgn_d   = bus.SgnIn;
      exp_d   = EW'(bus.ExpIn);
      man_d   = bus.ManIn;
      zero_d  = bus.ZeroIn;
      inf_d   = bus.InfIn;
      nan_d   = bus.NaNIn;
      snan_d  = bus.SNaNIn;
      lz_d    = '0;
      state_d = bus.SubnormIn ? ST_SHIFT : ST_DONE;
    end

    if (Flush) state_d = ST_IDLE;

    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      sgn_q   <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      zero_q  <= 1'b0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
      snan_q  <= 1'b0;
      lz_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      sgn_q   <= sgn_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      zero_q  <= zero_d;
      inf_q   <= inf_d;
      nan_q   <= nan_d;
      snan_q  <= snan_d;
      lz_q    <= lz_d;
    end
  end

  assign bus.InReady  = in_ready_c;
  assign bus.OutValid = valid_q;
  assign bus.SgnOut   = sgn_q;
  assign bus.ExpOut   = exp_q;
  assign bus.ManOut   = man_q;
  assign bus.ZeroOut  = zero_q;
  assign bus.InfOut   = inf_q;
  assign bus.NaNOut   = nan_q;
  assign bus.SNaNOut  = snan_q;
  assign bus.LzCnt    = lz_q;

endmodule

// File: tb/tb_fpu_subnorm_normalizer.sv
// Scoreboard bench for fpu_subnorm_normalizer in the double configuration (NF=52, NE=11, SHIFTW=8).
module tb_fpu_subnorm_normalizer;
  import fpu_subnorm_normalizer_pkg::*;

  localparam cvw_t        P      = DOUBLE_CFG;
  localparam int unsigned NF     = 52;
  localparam int unsigned NE     = 11;
  localparam int unsigned EW     = NE + 2;
  localparam int unsigned LW     = 6;
  localparam int unsigned SHIFTW = 8;

  typedef struct {
    logic          sgn;
    logic [EW-1:0] exp;
    logic [NF:0]   man;
    logic          zero;
    logic          inf;
    logic          nan;
    logic          snan;
    logic [LW-1:0] lz;
    int            lat;
    int            push_cyc;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic Flush   = 1'b0;

  fpu_subnorm_normalizer_if #(.P(P)) bus ();

  fpu_subnorm_normalizer #(.P(P), .SHIFTW(SHIFTW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Flush   (Flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  bit   head_seen   = 1'b0;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: subnormal result is the significand shifted by its full leading-zero count.
  function automatic exp_t model(input logic sgn, input logic [NE-1:0] e, input logic [NF:0] m,
                                 input logic sub, input logic z, input logic i, input logic n,
                                 input logic s);
    exp_t r;
    int   l;
    bit   found;
    l     = 0;
    found = 1'b0;
    for (int b = NF; b >= 0; b--) begin
      if (m[b]) found = 1'b1;
      if (!found) l++;
    end
    r.sgn = sgn; r.zero = z; r.inf = i; r.nan = n; r.snan = s; r.push_cyc = 0;
    if (sub) begin
      r.man = m << l;
      r.exp = EW'(1 - l);
      r.lz  = LW'(l);
      r.lat = l / int'(SHIFTW) + 2;
    end else begin
      r.man = m;
      r.exp = {2'b00, e};
      r.lz  = '0;
      r.lat = 1;
    end
    return r;
  endfunction

  // Monitor: first-valid latency check, then full result check on the transfer cycle.
  always @(negedge clk) begin
    if (bus.OutValid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: OutValid=1 with empty scoreboard at cycle %0d", cyc);
      end else begin
        if (!head_seen) begin
          head_seen = 1'b1;
          vectors++;
          if ((cyc - sb[0].push_cyc) !== sb[0].lat) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, want %0d", cyc - sb[0].push_cyc, sb[0].lat);
          end
        end
        if (bus.OutReady) begin
          vectors++;
          if ({bus.SgnOut, bus.ExpOut, bus.ManOut, bus.ZeroOut, bus.InfOut, bus.NaNOut,
               bus.SNaNOut, bus.LzCnt} !==
              {sb[0].sgn, sb[0].exp, sb[0].man, sb[0].zero, sb[0].inf, sb[0].nan,
               sb[0].snan, sb[0].lz}) begin
            miscompares++;
            $display("FAIL result: got s=%0b e=%0d m=%h z%0b i%0b n%0b sn%0b lz=%0d, want s=%0b e=%0d m=%h z%0b i%0b n%0b sn%0b lz=%0d",
                     bus.SgnOut, $signed(bus.ExpOut), bus.ManOut, bus.ZeroOut, bus.InfOut,
                     bus.NaNOut, bus.SNaNOut, bus.LzCnt, sb[0].sgn, $signed(sb[0].exp),
                     sb[0].man, sb[0].zero, sb[0].inf, sb[0].nan, sb[0].snan, sb[0].lz);
          end
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input logic sgn, input logic [NE-1:0] e, input logic [NF:0] m,
                      input logic sub, input logic z, input logic i, input logic n,
                      input logic s);
    exp_t x;
    int   w;
    w = 0;
    assert (!(sub && m == '0)) else $fatal(1, "FAIL illegal_operand: subnormal with zero significand");
    bus.InValid = 1'b1; bus.SgnIn = sgn; bus.ExpIn = e; bus.ManIn = m;
    bus.SubnormIn = sub; bus.ZeroIn = z; bus.InfIn = i; bus.NaNIn = n; bus.SNaNIn = s;
    @(negedge clk);
    while (!bus.InReady && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.InReady) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: InReady=0 after %0d cycles, want 1", w);
    end else begin
      x = model(sgn, e, m, sub, z, i, n, s);
      x.push_cyc = cyc;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d results pending, want 0", sb.size());
      sb.delete();
      head_seen = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({bus.InReady, bus.OutValid, bus.SgnOut, bus.ExpOut, bus.ManOut, bus.ZeroOut,
         bus.InfOut, bus.NaNOut, bus.SNaNOut, bus.LzCnt} !== '0) begin
      miscompares++;
      $display("FAIL %s: got rdy=%0b vld=%0b e=%h m=%h lz=%0d, want all 0", tag, bus.InReady,
               bus.OutValid, bus.ExpOut, bus.ManOut, bus.LzCnt);
    end
  endtask

  task automatic test_reset();
    bus.InValid = 1'b0; bus.OutReady = 1'b1; bus.SgnIn = 1'b0; bus.ExpIn = '0; bus.ManIn = '0;
    bus.SubnormIn = 1'b0; bus.ZeroIn = 1'b0; bus.InfIn = 1'b0; bus.NaNIn = 1'b0; bus.SNaNIn = 1'b0;
    #1 reset_n = 1'b0;
    #2 check_all_zero("reset_state");
    #20 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_normal();
    send(1'b0, 11'd1023, 53'h18000000000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_subnormal();
    send(1'b0, 11'd1, 53'h00000000000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain();
    send(1'b1, 11'd1, 53'h08000000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain();
    send(1'b0, 11'd1, 53'h00000000000100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 11'd1, 53'h00800000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    send(1'b1, 11'd0,    53'h0,              1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b0, 11'd2047, 53'h18000000000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b1, 11'd2047, 53'h14000000000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(1'b0, 11'd1,    53'h10000000000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_stall();
    exp_t x;
    int   w;
    w = 0;
    bus.OutReady = 1'b0;
    x = model(1'b0, 11'd1, 53'h00004000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 11'd1, 53'h00004000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    while (!bus.OutValid && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.OutValid, bus.InReady, bus.ExpOut, bus.ManOut, bus.LzCnt} !==
          {1'b1, 1'b0, x.exp, x.man, x.lz}) begin
        miscompares++;
        $display("FAIL stall_hold: got vld=%0b rdy=%0b e=%0d m=%h lz=%0d, want vld=1 rdy=0 e=%0d m=%h lz=%0d",
                 bus.OutValid, bus.InReady, $signed(bus.ExpOut), bus.ManOut, bus.LzCnt,
                 $signed(x.exp), x.man, x.lz);
      end
    end
    @(posedge clk);
    #1;
    bus.OutReady = 1'b1;
    send(1'b0, 11'd1, 53'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_flush();
    bus.InValid = 1'b1; bus.SgnIn = 1'b0; bus.ExpIn = 11'd1; bus.ManIn = 53'h1;
    bus.SubnormIn = 1'b1; bus.ZeroIn = 1'b0; bus.InfIn = 1'b0; bus.NaNIn = 1'b0; bus.SNaNIn = 1'b0;
    @(posedge clk);
    #1 bus.InValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 Flush = 1'b1;
    bus.InValid = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.InReady !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got InReady=%0b, want 0", bus.InReady);
    end
    @(posedge clk);
    #1 Flush = 1'b0;
    bus.InValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.OutValid, bus.InReady} !== 2'b01) begin
        miscompares++;
        $display("FAIL flush_idle: got vld=%0b rdy=%0b, want vld=0 rdy=1", bus.OutValid, bus.InReady);
      end
    end
    @(posedge clk);
    #1;
    send(1'b1, 11'd1000, 53'h1abcdef0123456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_async_reset();
    bus.InValid = 1'b1; bus.SgnIn = 1'b1; bus.ExpIn = 11'd1; bus.ManIn = 53'h1;
    bus.SubnormIn = 1'b1; bus.ZeroIn = 1'b0; bus.InfIn = 1'b0; bus.NaNIn = 1'b0; bus.SNaNIn = 1'b0;
    @(posedge clk);
    #1 bus.InValid = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 11'd2047, 53'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_random();
    logic [63:0] rr;
    logic [NF:0] m;
    logic [NF:0] mask;
    int          pos;
    for (int k = 0; k < 24; k++) begin
      rr = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) != 0) begin
        pos  = $urandom_range(0, 51);
        mask = (53'h1 << (pos + 1)) - 53'h1;
        m    = (rr[NF:0] & mask) | (53'h1 << pos);
        send(rr[63], 11'd1, m, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        m = rr[NF:0] | (53'h1 << NF);
        send(rr[63], 11'(1 + $urandom_range(0, 2045)), m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_subnormal();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_subnorm_normalizer.md
Name: fpu_subnorm_normalizer

Overview:
- Sits directly downstream of the FPU operand unpacker; consumes one unpacked operand (sign, exponent, significand, class flags).
- Produces a significand with an explicit leading 1 and a signed extended exponent, so divide/sqrt and conversion units need no subnormal handling.
- Normal, zero, Inf and NaN operands bypass in one cycle.
- Subnormals are normalized iteratively, SHIFTW bit positions per cycle, under valid/ready handshakes on both sides.

Parameters:
- P, cvw_t, core configuration; supplies P.NE, P.NF.
- SHIFTW, 8, maximum left-shift per cycle; legal range 1..P.NF.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- Flush  in  1  abort the in-flight operation
- InValid  in  1  upstream operand valid
- InReady  out  1  block can accept an operand
- SgnIn  in  1  sign
- ExpIn  in  P.NE  biased exponent; subnormals arrive as 1
- ManIn  in  P.NF+1  significand, hidden bit at [P.NF]
- SubnormIn, ZeroIn, InfIn, NaNIn, SNaNIn  in  1 each  class flags
- OutValid  out  1  result valid
- OutReady  in  1  downstream accepts result
- SgnOut  out  1  sign
- ExpOut  out  P.NE+2  two's-complement normalized biased exponent
- ManOut  out  P.NF+1  normalized significand; [P.NF]=1 unless zero/Inf/NaN
- ZeroOut, InfOut, NaNOut, SNaNOut  out  1 each  registered flags
- LzCnt  out  $clog2(P.NF+1)  total left shift applied

Behaviour:
- States: IDLE, SHIFT, DONE. Reset (reset_n low, async) gives state IDLE and all outputs 0, including InReady.
- InReady = (IDLE) | (DONE & OutReady). Combinational; does not depend on InValid.
- Accept occurs when InValid & InReady at a clk edge. On accept, all inputs are registered, ExpIn is zero-extended to P.NE+2 bits, and LzCnt is set to 0.
  - SubnormIn=1: go to SHIFT.
  - Otherwise: go to DONE with values passed through unchanged. OutValid is high the cycle after accept (latency 1).
- SHIFT, each cycle, with top = Man[P.NF:P.NF-SHIFTW+1]:
  - top all zero: Man <<= SHIFTW; Exp -= SHIFTW; LzCnt += SHIFTW; stay in SHIFT.
  - Otherwise: k = leading-zero count of top (0..SHIFTW-1); Man <<= k; Exp -= k; LzCnt += k; go to DONE.
- SHIFT cycles = floor(L/SHIFTW)+1, where L is the leading-zero count of ManIn. Latency from accept to OutValid = floor(L/SHIFTW)+2.
- SubnormIn with ManIn==0 is illegal. The bench asserts it never occurs; the RTL need not handle it.
- Result: ExpOut = 1 - L, range 1-P.NF..1, so it fits in P.NE+2 signed bits. Shifts fill with 0; no bits are lost.
- DONE: OutValid=1; outputs are held stable until OutReady.
  - OutReady & InValid: back-to-back accept, same rules as from IDLE.
  - OutReady & ~InValid: go to IDLE, OutValid=0.
- Flush (synchronous, highest priority after reset): go to IDLE and clear OutValid next cycle. It discards any operand accepted in the same cycle. InReady is forced 0 while Flush is high.
- Async reset mid-SHIFT: immediate IDLE, outputs 0. After deassertion the block accepts on the first edge with InValid.
- OutValid never drops without OutReady, except on Flush or reset.

Decomposition:
- cvw package: no new typedefs. A localparam for exponent width (P.NE+2) is defined locally.
- One sub-module: fpu_chunk_lzc, a combinational priority encoder over SHIFTW bits returning zero-flag and count. It is reused by later iterative shifters.

Test Plan (double config, P.NF=52, P.NE=11, SHIFTW=8):
- Normal 1.5 (ExpIn=1023, ManIn=0x18000000000000) -> OutValid 1 cycle after accept; ExpOut=1023, ManOut unchanged, LzCnt=0.
- Subnormal ManIn=0x00000000000001, ExpIn=1 -> 7 SHIFT cycles, OutValid 8 cycles after accept; ManOut=0x10000000000000, ExpOut=-51, LzCnt=52.
- Subnormal ManIn=0x08000000000000 -> 1 SHIFT cycle; ExpOut=0, LzCnt=1, ManOut=0x10000000000000.
- OutReady held 0 for 5 cycles in DONE -> outputs stable, InReady=0. Then OutReady=1 with InValid=1 (ZeroIn) -> back-to-back accept; next result ZeroOut=1, ExpOut=1, ManOut=0.
- Flush asserted in 3rd SHIFT cycle of the L=52 case -> IDLE next cycle, OutValid never rises; next normal operand completes with latency 1.
- reset_n pulsed low mid-SHIFT, asynchronous to clk -> outputs 0 immediately; after release, an Inf operand gives InfOut=1, ExpOut=2047 with latency 1.
